// File: rtl/ring_frc_from_remote_controller_pkg.sv
// Shared MD definitions for the remote force receive path: widths, packet field offsets,
// receive FSM states and the ingress FIFO entry layout.
package ring_frc_from_remote_controller_pkg;

  localparam int unsigned NODE_ID_WIDTH        = 3;
  localparam int unsigned FLOAT_STRUCT_WIDTH   = 32;
  localparam int unsigned GLOBAL_CELL_ID_WIDTH = 3;
  localparam int unsigned PARTICLE_ID_WIDTH    = 4;
  localparam int unsigned GCID_WIDTH           = 3 * GLOBAL_CELL_ID_WIDTH;

  // Packet layout, MSB first: {valid, last, dest_id, src_id, gcid, parid, frc}
  localparam int unsigned FRC_LSB               = 0;
  localparam int unsigned PARID_LSB             = FRC_LSB + FLOAT_STRUCT_WIDTH;
  localparam int unsigned GCID_LSB              = PARID_LSB + PARTICLE_ID_WIDTH;
  localparam int unsigned SRC_LSB               = GCID_LSB + GCID_WIDTH;
  localparam int unsigned DEST_LSB              = SRC_LSB + NODE_ID_WIDTH;
  localparam int unsigned LAST_BIT              = DEST_LSB + NODE_ID_WIDTH;
  localparam int unsigned VALID_BIT             = LAST_BIT + 1;
  localparam int unsigned AXIS_PKT_STRUCT_WIDTH = VALID_BIT + 1;

  typedef enum logic [1:0] {
    StIdle,
    StRecv,
    StDrain,
    StDone
  } rx_state_e;

  typedef struct packed {
    logic [2:0]                    src_onehot;
    logic                          last;
    logic [GCID_WIDTH-1:0]         gcid;
    logic [PARTICLE_ID_WIDTH-1:0]  parid;
    logic [FLOAT_STRUCT_WIDTH-1:0] frc;
  } rx_entry_t;

  // Neighbour classification: [0]=Z {x,y,~z}, [1]=X {~x,y,z}, [2]=XZ {~x,y,~z}; 0 if unknown.
  function automatic logic [2:0] src_onehot(input logic [NODE_ID_WIDTH-1:0] own,
                                            input logic [NODE_ID_WIDTH-1:0] src);
    logic [2:0] oh;
    oh    = '0;
    oh[0] = (src == (own ^ 3'b001));
    oh[1] = (src == (own ^ 3'b100));
    oh[2] = (src == (own ^ 3'b101));
    return oh;
  endfunction

endpackage

// File: rtl/ring_frc_rx_fifo.sv
// Ingress packet FIFO with a registered head; the head counts as one of the Depth entries.
module ring_frc_rx_fifo
  import ring_frc_from_remote_controller_pkg::*;
#(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [Width-1:0] wdata,
  input  logic             pop,
  output logic [Width-1:0] rdata,
  output logic             rvalid,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AddrW = $clog2(Depth);
  typedef logic [AddrW:0] cnt_t;

  logic [Width-1:0] mem_q [Depth];
  logic [AddrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AddrW-1:0] rd_ptr_q, rd_ptr_d;
  cnt_t             cnt_q, cnt_d;
  logic             rvalid_q, rvalid_d;
  logic [Width-1:0] rdata_q, rdata_d;

  // The head register samples memory before this edge's write, so a fresh entry into an
  // empty FIFO becomes visible one cycle after it lands.
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AddrW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + AddrW'(1) : rd_ptr_q;
    cnt_d    = cnt_q + cnt_t'(push) - cnt_t'(pop);
    rvalid_d = cnt_q > cnt_t'(pop);
    rdata_d  = mem_q[rd_ptr_d];
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
    end
  end

  assign rdata  = rdata_q;
  assign rvalid = rvalid_q;
  assign full   = (cnt_q == cnt_t'(Depth));
  assign empty  = (cnt_q == '0);

endmodule

// File: rtl/ring_frc_from_remote_controller.sv
// Receives force packets from the three ring neighbours, buffers them and streams them to the
// local force cache, tracking per-source burst completion for each evaluation round.
module ring_frc_from_remote_controller
  import ring_frc_from_remote_controller_pkg::*;
#(
  parameter int unsigned NODE_ID_WIDTH = 3,
  parameter int unsigned FIFO_DEPTH    = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NODE_ID_WIDTH-1:0]         i_init_id,
  input  logic                             i_remote_frc_eval_flag,
  input  logic [AXIS_PKT_STRUCT_WIDTH-1:0] i_axis_frc_pkt_from_remote,
  input  logic                             i_frc_ready,
  output logic [FLOAT_STRUCT_WIDTH-1:0]    o_frc_from_remote,
  output logic [GCID_WIDTH-1:0]            o_frc_gcid_from_remote,
  output logic [PARTICLE_ID_WIDTH-1:0]     o_frc_parid_from_remote,
  output logic                             o_frc_from_remote_valid,
  output logic [2:0]                       o_src_onehot,
  output logic                             o_all_remote_frc_received,
  output logic                             o_debug_overflow,
  output logic                             o_debug_bad_pkt
);

  localparam int unsigned EntryW = $bits(rx_entry_t);

  rx_state_e         state_q, state_d;
  logic              eval_q;
  logic [2:0]        done_q, done_d;
  logic [2:0][15:0]  beat_cnt_q, beat_cnt_d;
  logic              ovf_q, bad_q;

  logic [NODE_ID_WIDTH-1:0] pkt_dest, pkt_src;
  logic [2:0]               pkt_oh;
  logic                     pkt_valid, pkt_hit, pkt_bad;
  logic                     fifo_push, fifo_pop, fifo_full, fifo_empty, fifo_rvalid, ovf;
  logic [EntryW-1:0]        fifo_rdata;
  rx_entry_t                wr_entry, head;
  logic                     eval_rise, round_start, out_en, out_valid;

  assign pkt_valid = i_axis_frc_pkt_from_remote[VALID_BIT];
  assign pkt_dest  = i_axis_frc_pkt_from_remote[DEST_LSB +: NODE_ID_WIDTH];
  assign pkt_src   = i_axis_frc_pkt_from_remote[SRC_LSB +: NODE_ID_WIDTH];
  assign pkt_oh    = src_onehot(i_init_id, pkt_src);
  assign pkt_hit   = pkt_valid && (pkt_dest == i_init_id) && (pkt_oh != 3'b000);
  assign pkt_bad   = pkt_valid && !pkt_hit;

  always_comb begin
    wr_entry            = '0;
    wr_entry.src_onehot = pkt_oh;
    wr_entry.last       = i_axis_frc_pkt_from_remote[LAST_BIT];
    wr_entry.gcid       = i_axis_frc_pkt_from_remote[GCID_LSB +: GCID_WIDTH];
    wr_entry.parid      = i_axis_frc_pkt_from_remote[PARID_LSB +: PARTICLE_ID_WIDTH];
    wr_entry.frc        = i_axis_frc_pkt_from_remote[FRC_LSB +: FLOAT_STRUCT_WIDTH];
  end

  // A pop in the same cycle frees the slot, so a full FIFO can still take a packet.
  assign fifo_push = pkt_hit && (!fifo_full || fifo_pop);
  assign ovf       = pkt_hit && fifo_full && !fifo_pop;

  assign head      = rx_entry_t'(fifo_rdata);
  assign out_en    = (state_q == StRecv) || (state_q == StDrain);
  assign out_valid = fifo_rvalid && out_en;
  assign fifo_pop  = out_valid && i_frc_ready;
  assign eval_rise = i_remote_frc_eval_flag && !eval_q;

  ring_frc_rx_fifo #(
    .Width (EntryW),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push   (fifo_push),
    .wdata  (EntryW'(wr_entry)),
    .pop    (fifo_pop),
    .rdata  (fifo_rdata),
    .rvalid (fifo_rvalid),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  always_comb begin
    state_d     = state_q;
    round_start = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (eval_rise) begin
          state_d     = StRecv;
          round_start = 1'b1;
        end
      end
      StRecv: begin
        if (&done_q) state_d = StDrain;
      end
      StDrain: begin
        if (fifo_empty) state_d = StDone;
      end
      StDone: begin
        if (eval_rise) begin
          state_d     = StRecv;
          round_start = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Completion and beat counts follow what the cache has consumed, not what has arrived.
  always_comb begin
    done_d     = done_q;
    beat_cnt_d = beat_cnt_q;
    if (round_start) begin
      done_d     = '0;
      beat_cnt_d = '0;
    end else if (fifo_pop) begin
      if (head.last) done_d = done_q | head.src_onehot;
      for (int i = 0; i < 3; i++) begin
        if (head.src_onehot[i] && (beat_cnt_q[i] != 16'hFFFF)) begin
          beat_cnt_d[i] = beat_cnt_q[i] + 16'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      eval_q     <= 1'b0;
      done_q     <= '0;
      beat_cnt_q <= '0;
      ovf_q      <= 1'b0;
      bad_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      eval_q     <= i_remote_frc_eval_flag;
      done_q     <= done_d;
      beat_cnt_q <= beat_cnt_d;
      ovf_q      <= ovf_q | ovf;
      bad_q      <= bad_q | pkt_bad;
    end
  end

  assign o_frc_from_remote_valid   = out_valid;
  assign o_frc_from_remote         = out_valid ? head.frc : '0;
  assign o_frc_gcid_from_remote    = out_valid ? head.gcid : '0;
  assign o_frc_parid_from_remote   = out_valid ? head.parid : '0;
  assign o_src_onehot              = out_valid ? head.src_onehot : '0;
  assign o_all_remote_frc_received = (state_q == StDone);
  assign o_debug_overflow          = ovf_q;
  assign o_debug_bad_pkt           = bad_q;

endmodule

// File: tb/tb_ring_frc_from_remote_controller.sv
// Directed self-checking bench for ring_frc_from_remote_controller (own id 3'b000).
`timescale 1ns/1ps
module tb_ring_frc_from_remote_controller;
  import ring_frc_from_remote_controller_pkg::*;

  logic                             clk = 1'b0;
  logic                             rst;
  logic [2:0]                       init_id;
  logic                             eval;
  logic [AXIS_PKT_STRUCT_WIDTH-1:0] pkt;
  logic                             ready;
  logic [FLOAT_STRUCT_WIDTH-1:0]    o_frc;
  logic [GCID_WIDTH-1:0]            o_gcid;
  logic [PARTICLE_ID_WIDTH-1:0]     o_parid;
  logic                             o_valid;
  logic [2:0]                       o_src;
  logic                             o_all;
  logic                             o_ovf;
  logic                             o_bad;

  int compared   = 0;
  int mismatched = 0;
  logic [47:0] cap_q [$];

  ring_frc_from_remote_controller #(
    .NODE_ID_WIDTH (3),
    .FIFO_DEPTH    (16)
  ) dut (
    .clk                        (clk),
    .rst                        (rst),
    .i_init_id                  (init_id),
    .i_remote_frc_eval_flag     (eval),
    .i_axis_frc_pkt_from_remote (pkt),
    .i_frc_ready                (ready),
    .o_frc_from_remote          (o_frc),
    .o_frc_gcid_from_remote     (o_gcid),
    .o_frc_parid_from_remote    (o_parid),
    .o_frc_from_remote_valid    (o_valid),
    .o_src_onehot               (o_src),
    .o_all_remote_frc_received  (o_all),
    .o_debug_overflow           (o_ovf),
    .o_debug_bad_pkt            (o_bad)
  );

  always #5 clk = ~clk;

  // Inputs change only at posedge+1, so a beat seen here is consumed at the next posedge.
  always @(negedge clk) begin
    if (o_valid && ready) cap_q.push_back({o_src, o_gcid, o_parid, o_frc});
  end

  function automatic logic [8:0] gcid_of(input logic [31:0] f);
    return f[8:0] ^ 9'h0A5;
  endfunction

  function automatic logic [3:0] parid_of(input logic [31:0] f);
    return f[3:0] ^ 4'h3;
  endfunction

  function automatic logic [47:0] beat(input logic [2:0] oh, input logic [31:0] f);
    return {oh, gcid_of(f), parid_of(f), f};
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic last, input logic [2:0] dest, input logic [2:0] src,
                      input logic [31:0] f);
    pkt = {1'b1, last, dest, src, gcid_of(f), parid_of(f), f};
    cyc();
    pkt = '0;
  endtask

  task automatic start_round();
    eval = 1'b1;
    cyc();
    eval = 1'b0;
  endtask

  task automatic check_cap(input string tag, input int idx, input logic [47:0] exp);
    if (idx < cap_q.size()) check(tag, cap_q[idx], exp);
    else check(tag, 64'hDEAD_0000_0000_0000, exp);
  endtask

  initial begin
    rst = 1'b1; init_id = 3'b000; eval = 1'b0; pkt = '0; ready = 1'b1;
    repeat (3) cyc();
    check("rst_valid", o_valid, 1'b0);
    check("rst_frc", o_frc, 32'h0);
    check("rst_src", o_src, 3'b000);
    check("rst_all", o_all, 1'b0);
    check("rst_ovf", o_ovf, 1'b0);
    check("rst_bad", o_bad, 1'b0);
    check("rst_state", 64'(dut.state_q), 64'(StIdle));
    rst = 1'b0;
    cyc();

    // Round 1: Z burst of 4 with 2-cycle latency on the first beat
    start_round();
    check("r1_state_recv", 64'(dut.state_q), 64'(StRecv));
    send(1'b0, 3'b000, 3'b001, 32'd100);
    check("lat_cycle1_valid", o_valid, 1'b0);
    cyc();
    check("lat_cycle2_valid", o_valid, 1'b1);
    check("lat_cycle2_frc", o_frc, 32'd100);
    check("lat_cycle2_src", o_src, 3'b001);
    send(1'b0, 3'b000, 3'b001, 32'd101);
    send(1'b0, 3'b000, 3'b001, 32'd102);
    send(1'b1, 3'b000, 3'b001, 32'd103);
    repeat (6) cyc();
    check("z_beats", cap_q.size(), 4);
    for (int i = 0; i < 4; i++) check_cap("z_beat", i, beat(3'b001, 32'd100 + 32'(i)));
    check("z_done", dut.done_q, 3'b001);
    check("z_all", o_all, 1'b0);

    // Misrouted packets: wrong dest, then unknown source
    send(1'b1, 3'b010, 3'b001, 32'd150);
    cyc();
    check("bad_dest_flag", o_bad, 1'b1);
    send(1'b1, 3'b000, 3'b010, 32'd151);
    repeat (4) cyc();
    check("bad_no_beat", cap_q.size(), 4);
    check("bad_valid", o_valid, 1'b0);
    check("bad_no_ovf", o_ovf, 1'b0);

    // X burst of 2 and XZ burst of 1 complete the round
    send(1'b0, 3'b000, 3'b100, 32'd200);
    send(1'b1, 3'b000, 3'b100, 32'd201);
    send(1'b1, 3'b000, 3'b101, 32'd300);
    repeat (8) cyc();
    check("r1_beats", cap_q.size(), 7);
    check_cap("x_beat0", 4, beat(3'b010, 32'd200));
    check_cap("x_beat1", 5, beat(3'b010, 32'd201));
    check_cap("xz_beat0", 6, beat(3'b100, 32'd300));
    check("r1_all", o_all, 1'b1);
    check("r1_state_done", 64'(dut.state_q), 64'(StDone));
    check("r1_cnt_z", dut.beat_cnt_q[0], 16'd4);
    check("r1_cnt_x", dut.beat_cnt_q[1], 16'd2);
    check("r1_cnt_xz", dut.beat_cnt_q[2], 16'd1);

    // Round 2: 17 packets into a stalled cache overflow by one
    start_round();
    check("r2_state_recv", 64'(dut.state_q), 64'(StRecv));
    check("r2_all_dropped", o_all, 1'b0);
    check("r2_done_clr", dut.done_q, 3'b000);
    check("r2_cnt_clr", dut.beat_cnt_q[0], 16'd0);
    ready = 1'b0;
    for (int i = 0; i < 17; i++) send(i == 15, 3'b000, 3'b001, 32'd400 + 32'(i));
    check("ovf_flag", o_ovf, 1'b1);
    check("ovf_head_valid", o_valid, 1'b1);
    check("ovf_head_frc", o_frc, 32'd400);
    check("bad_sticky", o_bad, 1'b1);
    ready = 1'b1;
    repeat (20) cyc();
    check("ovf_beats", cap_q.size(), 23);
    for (int i = 0; i < 16; i++) check_cap("ovf_beat", 7 + i, beat(3'b001, 32'd400 + 32'(i)));
    check("ovf_cnt_z", dut.beat_cnt_q[0], 16'd16);
    check("ovf_done", dut.done_q, 3'b001);

    // Ready toggling: head must hold while stalled
    ready = 1'b0;
    for (int i = 0; i < 4; i++) send(i == 3, 3'b000, 3'b100, 32'd500 + 32'(i));
    for (int i = 0; i < 12; i++) begin
      logic [31:0] snap;
      logic        snapped;
      ready   = i[0];
      snapped = !ready && o_valid;
      snap    = o_frc;
      cyc();
      if (snapped) begin
        check("stall_valid", o_valid, 1'b1);
        check("stall_frc", o_frc, snap);
      end
    end
    ready = 1'b1;
    repeat (3) cyc();
    check("tog_beats", cap_q.size(), 27);
    for (int i = 0; i < 4; i++) check_cap("tog_beat", 23 + i, beat(3'b010, 32'd500 + 32'(i)));
    check("tog_cnt_x", dut.beat_cnt_q[1], 16'd4);
    check("tog_done", dut.done_q, 3'b011);

    // Reset mid-round abandons buffered packets
    ready = 1'b0;
    send(1'b0, 3'b000, 3'b101, 32'd600);
    send(1'b0, 3'b000, 3'b101, 32'd601);
    rst = 1'b1;
    cyc();
    check("mrst_valid", o_valid, 1'b0);
    check("mrst_frc", o_frc, 32'h0);
    check("mrst_ovf", o_ovf, 1'b0);
    check("mrst_bad", o_bad, 1'b0);
    check("mrst_state", 64'(dut.state_q), 64'(StIdle));
    check("mrst_done", dut.done_q, 3'b000);
    rst = 1'b0;
    ready = 1'b1;
    cyc();
    start_round();
    check("r3_state_recv", 64'(dut.state_q), 64'(StRecv));
    send(1'b1, 3'b000, 3'b001, 32'd700);
    send(1'b1, 3'b000, 3'b100, 32'd701);
    send(1'b1, 3'b000, 3'b101, 32'd702);
    repeat (10) cyc();
    check("r3_beats", cap_q.size(), 30);
    check_cap("r3_beat_z", 27, beat(3'b001, 32'd700));
    check_cap("r3_beat_x", 28, beat(3'b010, 32'd701));
    check_cap("r3_beat_xz", 29, beat(3'b100, 32'd702));
    check("r3_all", o_all, 1'b1);
    check("r3_cnt_z", dut.beat_cnt_q[0], 16'd1);
    check("r3_cnt_x", dut.beat_cnt_q[1], 16'd1);
    check("r3_cnt_xz", dut.beat_cnt_q[2], 16'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/ring_frc_from_remote_controller.md
RING_FRC_FROM_REMOTE_CONTROLLER -- requirements
Module: ring_frc_from_remote_controller

Interface
REQ-001 SHALL have parameter NODE_ID_WIDTH, default 3, giving the node id width as {x, y, z}, 1 bit each.
REQ-002 SHALL have parameter FIFO_DEPTH, default 16, giving the ingress buffer depth in packets (power of two).
REQ-003 SHALL have port clk, input, 1 bit: the single clock.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-005 SHALL have port i_init_id, input, NODE_ID_WIDTH bits: own node id, static after reset.
REQ-006 SHALL have port i_remote_frc_eval_flag, input, 1 bit: a rising edge opens a new receive round.
REQ-007 SHALL have port i_axis_frc_pkt_from_remote, input, AXIS_PKT_STRUCT_WIDTH bits: network packet with layout {valid, last, dest_id, src_id, gcid[3*GLOBAL_CELL_ID_WIDTH], parid[PARTICLE_ID_WIDTH], frc[FLOAT_STRUCT_WIDTH]}, MSB first; there is no ready.
REQ-008 SHALL have port i_frc_ready, input, 1 bit: the downstream force cache accepts this cycle.
REQ-009 SHALL have port o_frc_from_remote, output, FLOAT_STRUCT_WIDTH bits: the force.
REQ-010 SHALL have port o_frc_gcid_from_remote, output, 3*GLOBAL_CELL_ID_WIDTH bits: the target cell.
REQ-011 SHALL have port o_frc_parid_from_remote, output, PARTICLE_ID_WIDTH bits: the target particle.
REQ-012 SHALL have port o_frc_from_remote_valid, output, 1 bit: output beat valid.
REQ-013 SHALL have port o_src_onehot, output, 3 bits: source of the current beat, with [0]=Z, [1]=X, [2]=XZ.
REQ-014 SHALL have port o_all_remote_frc_received, output, 1 bit: all three bursts of the round are complete.
REQ-015 SHALL have ports o_debug_overflow and o_debug_bad_pkt, outputs, 1 bit each: sticky error flags.

Function
REQ-016 SHALL compute the expected sources: Z={x,y,~z}, X={~x,y,z}, XZ={~x,y,~z}.
REQ-017 SHALL accept a packet with valid=1 and dest_id==i_init_id whose src_id matches one expected source; it SHALL write that packet plus its 3-bit source onehot into the FIFO in the same cycle.
REQ-018 SHALL drop a valid packet with a dest mismatch or an unknown src_id, and SHALL set o_debug_bad_pkt.
REQ-019 SHALL, when a packet is accepted while the FIFO is full, drop the packet, set o_debug_overflow, and leave FIFO contents unchanged.
REQ-020 SHALL present the FIFO head registered, with o_frc_from_remote_valid=1 while the FIFO is non-empty and the FSM is in RECV or DRAIN.
REQ-021 SHALL pop the FIFO only when valid&i_frc_ready; outputs SHALL hold stable while valid&~i_frc_ready.
REQ-022 SHALL have a latency of 2 cycles from packet input to output valid with an empty FIFO and ready held high.
REQ-023 SHALL support a simultaneous push and pop when full, which succeeds with no overflow.
REQ-024 SHALL keep a done bit per source, set when a packet with last=1 from that source is popped, not when it is pushed.
REQ-025 SHALL keep per-source 16-bit beat counters that increment on pop, saturate at 16'hFFFF, and clear at round start.
REQ-026 FSM states SHALL be IDLE, RECV, DRAIN, DONE.
REQ-027 In IDLE, a rising edge of i_remote_frc_eval_flag SHALL move the FSM to RECV and clear the done bits and counters.
REQ-028 In RECV, when all three done bits are set the FSM SHALL move to DRAIN.
REQ-029 In DRAIN, when the FIFO is empty the FSM SHALL move to DONE.
REQ-030 In DONE, o_all_remote_frc_received SHALL be 1; a new eval rising edge SHALL move the FSM to RECV, and the done flag SHALL drop the next cycle.
REQ-031 SHALL still push packets arriving in IDLE or DONE into the FIFO (early senders), but SHALL pop them only after entering RECV.
REQ-032 SHALL ignore a second last=1 packet from an already-done source for the done bit.

Reset
REQ-033 Reset SHALL clear all outputs to 0, empty the FIFO, clear the done bits, counters, sticky flags and edge-detect register, and put the FSM in IDLE.
REQ-034 Reset asserted mid-round SHALL abandon the round; the first post-reset eval edge SHALL start cleanly.

Structure
REQ-035 NODE_ID_WIDTH, FLOAT_STRUCT_WIDTH, GLOBAL_CELL_ID_WIDTH, PARTICLE_ID_WIDTH, AXIS_PKT_STRUCT_WIDTH, the packet field offsets and the FSM state enum SHALL live in the shared MD package.
REQ-036 The FIFO SHALL be one sub-module, ring_frc_rx_fifo (synchronous, registered output, full/empty outputs).

Verification
REQ-037 Own id 3'b000, eval edge, 4 packets from src 3'b001 with the last on the 4th -> 4 output beats in order, Z done bit set, o_all_remote_frc_received=0.
REQ-038 Then 2 packets from 3'b100 and 1 from 3'b101, all ending last -> o_all_remote_frc_received=1 after the FIFO drains, beat counters 4/2/1.
REQ-039 Packet with dest 3'b010 or src 3'b010 -> no output beat, o_debug_bad_pkt=1.
REQ-040 i_frc_ready=0 with 17 back-to-back packets -> 16 buffered, o_debug_overflow=1, then ready=1 yields exactly 16 beats.
REQ-041 Ready toggled every cycle -> output fields stable while stalled, no beat lost or duplicated.
REQ-042 rst pulsed after 2 of 4 packets -> all outputs 0 and state IDLE; a new round then completes normally.
